// File: rtl/matrix_scan_param.sv
// Row/bitplane scan sequencer for HUB75-style LED matrices: shifts a row, latches it,
// and times output_enable per bitplane. Define MATRIX_SCAN_BLANK_EN for row-change dead time.
module matrix_scan_param #(
  parameter int COLUMNS     = 64,
  parameter int ROW_BITS    = 4,
  parameter int PWM_BITS    = 6,
  parameter int BASE_OE     = 23,
  parameter int LATCH_WIDTH = 1
`ifdef MATRIX_SCAN_BLANK_EN
  ,
  parameter int BLANK_CYCLES = 4
`endif
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  input  logic                        scan_en,
  output logic [$clog2(COLUMNS)-1:0]  column_address,
  output logic [ROW_BITS-1:0]         row_address,
  output logic [ROW_BITS-1:0]         row_address_active,
  output logic [PWM_BITS-1:0]         brightness_mask,
  output logic [PWM_BITS-1:0]         brightness_mask_active,
  output logic                        clk_pixel_load_en,
  output logic                        clk_pixel_en,
  output logic                        row_latch,
  output logic                        output_enable,
  output logic                        frame_start
);

  localparam int CW     = $clog2(COLUMNS);
  localparam int OE_MAX = BASE_OE << (PWM_BITS - 1);
  localparam int OW     = $clog2(OE_MAX + 1);
  localparam int LCW    = $clog2(LATCH_WIDTH + 1);

  localparam logic [CW-1:0]       COL_LAST  = CW'(COLUMNS - 1);
  localparam logic [PWM_BITS-1:0] MASK_MSB  = PWM_BITS'(1) << (PWM_BITS - 1);
  localparam logic [LCW-1:0]      LATCH_END = LCW'(LATCH_WIDTH - 1);

  typedef enum logic [2:0] {LOAD, DRAIN, HOLD, LATCH, WAIT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 load_en_q, load_en_d;
  logic                 pix_en_q;
  logic [LCW-1:0]       latch_cnt_q, latch_cnt_d;
  logic [OW-1:0]        oe_cnt_q, oe_cnt_d, oe_load;
  logic [ROW_BITS-1:0]  row_q, row_d, row_act_q, row_act_d;
  logic [PWM_BITS-1:0]  mask_q, mask_d, mask_act_q, mask_act_d;
  logic                 frame_q, frame_d;
  logic                 oe_on_next;
  logic                 hold_done;

`ifdef MATRIX_SCAN_BLANK_EN
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  logic [BW-1:0] blank_q, blank_d;
`endif

  // OE period for the plane currently selected for loading.
  always_comb begin
    oe_load = '0;
    for (int i = 0; i < PWM_BITS; i++) begin
      if (mask_q[i]) oe_load = OW'(BASE_OE) << i;
    end
  end

  // The FSM looks one cycle ahead so the latch lands in the first dark cycle.
  assign oe_on_next = (oe_cnt_q > OW'(1));

`ifdef MATRIX_SCAN_BLANK_EN
  always_comb begin
    hold_done = 1'b0;
    if (oe_cnt_q == OW'(1))   hold_done = (blank_q == '0);
    else if (!oe_on_next)     hold_done = (blank_q <= BW'(1));
  end
`else
  assign hold_done = !oe_on_next;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    col_d       = col_q;
    load_en_d   = 1'b0;
    latch_cnt_d = '0;
    oe_cnt_d    = (oe_cnt_q != '0) ? oe_cnt_q - 1'b1 : '0;
    row_d       = row_q;
    row_act_d   = row_act_q;
    mask_d      = mask_q;
    mask_act_d  = mask_act_q;
    frame_d     = 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
    blank_d     = blank_q;
`endif

    unique case (state_q)
      LOAD: begin
        // Only the post-reset entry arrives here with the shift enable still low.
        if (!load_en_q) begin
          load_en_d = 1'b1;
          col_d     = COL_LAST;
        end else if (col_q == '0) begin
          state_d = DRAIN;
        end else begin
          load_en_d = 1'b1;
          col_d     = col_q - 1'b1;
        end
      end

      DRAIN: begin
`ifdef MATRIX_SCAN_BLANK_EN
        if (row_q != row_act_q) begin
          state_d = HOLD;
          blank_d = BW'(BLANK_CYCLES);
        end else if (oe_on_next) begin
          state_d = HOLD;
          blank_d = '0;
        end else begin
          state_d = LATCH;
        end
`else
        state_d = oe_on_next ? HOLD : LATCH;
`endif
      end

      HOLD: begin
        if (hold_done) begin
          state_d = LATCH;
        end
`ifdef MATRIX_SCAN_BLANK_EN
        else if (oe_cnt_q == '0) begin
          blank_d = blank_q - 1'b1;
        end
`endif
      end

      LATCH: begin
        if (latch_cnt_q == LATCH_END) begin
          state_d    = WAIT;
          row_act_d  = row_q;
          mask_act_d = mask_q;
          oe_cnt_d   = oe_load;
          frame_d    = (row_q == '0) && mask_q[PWM_BITS-1];
          if (mask_q[0]) begin
            mask_d = MASK_MSB;
            row_d  = row_q + 1'b1;
          end else begin
            mask_d = mask_q >> 1;
          end
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end

      WAIT: begin
        // oe_cnt_q includes the current cycle, so remaining-after-this <= COLUMNS+1.
        if (scan_en && (32'(oe_cnt_q) <= COLUMNS + 2)) begin
          state_d   = LOAD;
          load_en_d = 1'b1;
          col_d     = COL_LAST;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD;
      col_q       <= '0;
      load_en_q   <= 1'b0;
      pix_en_q    <= 1'b0;
      latch_cnt_q <= '0;
      oe_cnt_q    <= '0;
      row_q       <= '0;
      row_act_q   <= '0;
      mask_q      <= MASK_MSB;
      mask_act_q  <= '0;
      frame_q     <= 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      col_q       <= col_d;
      load_en_q   <= load_en_d;
      pix_en_q    <= load_en_q;
      latch_cnt_q <= latch_cnt_d;
      oe_cnt_q    <= oe_cnt_d;
      row_q       <= row_d;
      row_act_q   <= row_act_d;
      mask_q      <= mask_d;
      mask_act_q  <= mask_act_d;
      frame_q     <= frame_d;
`ifdef MATRIX_SCAN_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  // Both strobes decode straight from async-reset registers, so reset darkens them at once.
  assign row_latch              = (state_q == LATCH);
  assign output_enable          = (oe_cnt_q != '0);
  assign column_address         = col_q;
  assign clk_pixel_load_en      = load_en_q;
  assign clk_pixel_en           = pix_en_q;
  assign row_address            = row_q;
  assign row_address_active     = row_act_q;
  assign brightness_mask        = mask_q;
  assign brightness_mask_active = mask_act_q;
  assign frame_start            = frame_q;

endmodule

// File: doc/matrix_scan_param.md
MATRIX_SCAN_PARAM -- requirements
Module: matrix_scan_param

Interface
REQ-001 SHALL have parameter COLUMNS, default 64, pixels shifted per row; must be 2..1024.
REQ-002 SHALL have parameter ROW_BITS, default 4, row address width.
REQ-003 SHALL have parameter PWM_BITS, default 6, number of bitplanes.
REQ-004 SHALL have parameter BASE_OE, default 23, output_enable cycles for the LSB plane.
REQ-005 SHALL have parameter LATCH_WIDTH, default 1, row_latch high cycles (1..8).
REQ-006 SHALL have port clk_in, input, 1, the single clock; every register SHALL be clocked on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port scan_en, input, 1, permits starting a new row load.
REQ-009 SHALL have port column_address, output, clog2(COLUMNS), the column being shifted.
REQ-010 SHALL have ports row_address and row_address_active, output, ROW_BITS, the row being loaded and the row being displayed.
REQ-011 SHALL have ports brightness_mask and brightness_mask_active, output, PWM_BITS, one-hot plane select for load and display.
REQ-012 SHALL have ports clk_pixel_load_en, clk_pixel_en, row_latch and output_enable, output, 1 each; output_enable high means LEDs on.
REQ-013 SHALL have port frame_start, output, 1, single-cycle pulse.

Function
REQ-014 SHALL use FSM states LOAD, DRAIN, HOLD, LATCH and WAIT, with no gated clocks and no negedge logic.
REQ-015 In LOAD, clk_pixel_load_en SHALL be 1 for exactly COLUMNS cycles, with column_address running COLUMNS-1 down to 0, then the FSM SHALL go to DRAIN.
REQ-016 clk_pixel_en SHALL equal clk_pixel_load_en delayed by one cycle; DRAIN SHALL last 1 cycle.
REQ-017 DRAIN -> HOLD if output_enable=1, else -> LATCH; HOLD SHALL stay until output_enable=0.
REQ-018 In LATCH, row_latch SHALL be 1 for LATCH_WIDTH cycles, and output_enable SHALL never be 1 while row_latch=1.
REQ-019 On the last LATCH cycle, brightness_mask_active SHALL take brightness_mask, row_address_active SHALL take row_address, the OE timer SHALL load BASE_OE << p (p = index of the latched mask bit), and the FSM SHALL go to WAIT.
REQ-020 output_enable SHALL be high for exactly BASE_OE << p cycles, starting the cycle after LATCH exits; the OE counter width SHALL hold BASE_OE << (PWM_BITS-1) without overflow.
REQ-021 Mask advance SHALL be MSB plane first, shifting right; after the LSB plane, the mask SHALL return to the MSB plane and row_address SHALL increment by 1.
REQ-022 row_address SHALL wrap from 2^ROW_BITS-1 to 0.
REQ-023 frame_start SHALL pulse on the cycle after a LATCH that displays row 0 with the MSB plane.
REQ-024 WAIT -> LOAD when scan_en=1 and OE remaining <= COLUMNS+1, so that the next latch coincides with OE expiry; an OE period shorter than the load SHALL end during LOAD/DRAIN and skip HOLD.
REQ-025 scan_en=0 SHALL hold the FSM in WAIT, let the current OE period complete normally, and leave all addresses unchanged.
REQ-026 scan_en sampled low during LOAD, DRAIN, HOLD or LATCH SHALL NOT abort the row; the row SHALL complete through LATCH.

Reset
REQ-027 While reset_n=0, all outputs SHALL be 0 except brightness_mask, which SHALL be the MSB plane (1 << (PWM_BITS-1)); the FSM state SHALL be LOAD, and the OE timer and column counter SHALL be 0.
REQ-028 Reset asserted mid-LOAD or mid-OE SHALL force output_enable=0 and row_latch=0 immediately, without waiting for a clock.
REQ-029 The first cycle after reset release SHALL be LOAD cycle 0, with column_address=COLUMNS-1.

Configuration
REQ-030 Macro MATRIX_SCAN_BLANK_EN SHALL add parameter BLANK_CYCLES (default 4) and, when defined, SHALL hold HOLD for BLANK_CYCLES further cycles after output_enable falls, and SHALL take HOLD even when output_enable is already 0, but only when the latch changes row_address_active (anti-ghosting dead time).
REQ-031 Without MATRIX_SCAN_BLANK_EN, dead time SHALL be only the LATCH cycles and BLANK_CYCLES SHALL not exist.

Verification (defaults, macro undefined, cycle 0 = first cycle after reset release)
REQ-032 Reset release -> clk_pixel_load_en=1 cycles 0..63 with column 63..0; clk_pixel_en=1 cycles 1..64; row_latch=1 cycle 65; output_enable=1 cycles 66..801; brightness_mask_active=100000; frame_start=1 cycle 66.
REQ-033 Steady state -> each latch falls in the first cycle after OE falls, and OE widths follow 736, 368, 184, 92, 46, 23, then repeat with row_address_active incremented.
REQ-034 LSB plane (23 cycles) -> next LOAD starts immediately, OE falls during LOAD, HOLD is never entered.
REQ-035 Run 16 rows x 6 planes -> row_address wraps 15->0 and frame_start pulses exactly once per 96 latches.
REQ-036 Pulse reset_n low during OE of row 3 -> output_enable=0 asynchronously; the restart matches REQ-032.
REQ-037 With MATRIX_SCAN_BLANK_EN and BLANK_CYCLES=4 -> on row-change latches, output_enable is low for 4 cycles plus 1 latch cycle between planes; on same-row latches there are no extra low cycles.
